// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared state type and frame-length helper for the sipo receiver
// SIPO_PARITY_EN adds one trailing parity bit to every frame.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef SIPO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Serial samples taken per frame after the start pulse.
    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// rtl/sipo_bit_counter.sv - saturating sample counter with clear, enable and terminal-count flag
module sipo_bit_counter #(
    parameter int SEL = 4,
    parameter int TC  = 7
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);
    localparam logic [SEL-1:0] TC_VAL = SEL'(TC);

    logic [SEL-1:0] r_count;
    logic           w_tc;

    assign w_tc = (r_count == TC_VAL);
    assign o_tc = w_tc;

    // Holds at the terminal count rather than wrapping.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_tc) begin
            r_count <= r_count + SEL'(1);
        end
    end

endmodule

// File: rtl/sipo.sv
// rtl/sipo.sv - serial-in parallel-out receiver with valid/ready output and sticky overrun
// SIPO_PARITY_EN enables a trailing even-parity bit and the o_parity_err output.
module sipo
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL   = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_ser_in,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_par_out,
    output logic             o_out_valid,
    output logic             o_busy,
`ifdef SIPO_PARITY_EN
    output logic             o_parity_err,
`endif
    output logic             o_overrun
);
    localparam int FRAME_LEN = frame_len(WIDTH);

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_tc;
    logic                 w_in_shift;
    logic                 w_transfer;
    logic                 w_accept;
    logic [FRAME_LEN-2:0] r_shift;
    logic [FRAME_LEN-1:0] w_frame;
    logic [WIDTH-1:0]     r_par_out;
    logic                 r_out_valid;
    logic                 r_overrun;

    assign w_in_shift = (r_state == SHIFT);
    // A start coinciding with the final sample aborts the frame instead of completing it.
    assign w_transfer = w_in_shift && w_tc && !i_start;
    assign w_accept   = !r_out_valid || i_out_ready;
    // The final sample joins the stored ones directly, so the word is complete on that edge.
    assign w_frame    = {i_ser_in, r_shift};

    sipo_bit_counter #(
        .SEL(SEL),
        .TC (FRAME_LEN - 1)
    ) u_bit_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (i_start || w_transfer),
        .i_enable(w_in_shift),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_start) begin
            w_next_state = SHIFT;
        end else if (w_in_shift && w_tc) begin
            w_next_state = IDLE;
        end
    end

    always_comb begin
        o_busy = w_in_shift;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_start) begin
            r_shift <= '0;
        end else if (w_in_shift) begin
            r_shift <= w_frame[FRAME_LEN-1:1];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_par_out   <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_transfer && w_accept) begin
            r_par_out   <= w_frame[WIDTH-1:0];
            r_out_valid <= 1'b1;
        end else begin
            if (w_transfer) begin
                r_overrun <= 1'b1;
            end
            if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_parity_err <= 1'b0;
        end else if (w_transfer && w_accept) begin
            r_parity_err <= ^w_frame;
        end
    end

    assign o_parity_err = r_parity_err;
`endif

    assign o_par_out   = r_par_out;
    assign o_out_valid = r_out_valid;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_sipo.sv
// tb/tb_sipo.sv - scoreboard bench for sipo; define SIPO_PARITY_EN to exercise the parity build
module tb_sipo;
    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int LAT = FL + 1;

    typedef struct {
        int         cyc;
        logic [W-1:0] d;
        logic       pe;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ser;
    logic         rdy;
    logic [W-1:0] par;
    logic         vld;
    logic         busy;
    logic         ovr;
`ifdef SIPO_PARITY_EN
    logic         perr;
`endif

    exp_t q[$];
    exp_t cur;
    bit   have_cur = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   c;
    int   c2;

    sipo #(.WIDTH(W), .SEL(4)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_ser_in   (ser),
        .i_out_ready(rdy),
        .o_par_out  (par),
        .o_out_valid(vld),
        .o_busy     (busy),
`ifdef SIPO_PARITY_EN
        .o_parity_err(perr),
`endif
        .o_overrun  (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h at cycle %0d", name, act, cyc);
    endtask

    always @(negedge clk) begin
        if (vld) begin
            if (!have_cur) begin
                if (q.size() == 0) begin
                    flag("unexpected_word", par);
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    check("word_cycle", cyc, cur.cyc);
                    check("word_data", par, cur.d);
`ifdef SIPO_PARITY_EN
                    check("parity_err", perr, cur.pe);
`endif
                end
            end else begin
                check("word_held", par, cur.d);
            end
            if (rdy) have_cur = 1'b0;
        end else if (have_cur) begin
            flag("valid_lost", par);
            have_cur = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            ser   = 1'b1;
        end
    endtask

    task automatic drive_start(output int cs);
        tick();
        start = 1'b1;
        ser   = 1'b0;
        cs    = cyc;
    endtask

    task automatic drive_bits(input logic [W-1:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            start = 1'b0;
            ser   = d[k];
        end
    endtask

    task automatic push_exp(input int at, input logic [W-1:0] d, input logic p);
        exp_t e;
        e.cyc = at;
        e.d   = d;
        e.pe  = (^d) ^ p;
        q.push_back(e);
    endtask

    task automatic send_p(input logic [W-1:0] d, input logic p, input bit push, output int cs);
        drive_start(cs);
        drive_bits(d, W);
`ifdef SIPO_PARITY_EN
        tick();
        start = 1'b0;
        ser   = p;
`endif
        if (push) push_exp(cs + LAT, d, p);
    endtask

    task automatic send(input logic [W-1:0] d, input bit push, output int cs);
        send_p(d, ^d, push, cs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ser   = 1'b0;
        rdy   = 1'b1;
        repeat (3) tick();
        check("reset_par_out", par, 0);
        check("reset_valid", vld, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", ovr, 0);
`ifdef SIPO_PARITY_EN
        check("reset_parity_err", perr, 0);
`endif
        rst = 1'b0;

        // single frame, consumer ready
        send(8'hA5, 1'b1, c);
        check("busy_in_frame", busy, 1);
        idle(1);
        check("busy_after_frame", busy, 0);
        idle(4);

        // backpressure: second word dropped, overrun sticky
        rdy = 1'b0;
        send(8'h3C, 1'b1, c);
        send(8'hC3, 1'b0, c2);
        idle(12);
        check("overrun_set", ovr, 1);
        rdy = 1'b1;
        idle(3);
        check("overrun_sticky", ovr, 1);

        // reset mid-frame, with start held during reset
        drive_start(c);
        drive_bits(8'hFF, 4);
        tick();
        rst   = 1'b1;
        start = 1'b1;
        ser   = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", vld, 0);
        check("rst_mid_overrun", ovr, 0);
        check("rst_mid_par_out", par, 0);
        send(8'hFF, 1'b1, c);
        idle(3);

        // abort by restart four cycles in
        drive_start(c);
        drive_bits(8'h55, 3);
        drive_start(c2);
        drive_bits(8'h81, W);
`ifdef SIPO_PARITY_EN
        tick();
        start = 1'b0;
        ser   = 1'b0;
`endif
        push_exp(c2 + LAT, 8'h81, 1'b0);
        idle(3);

        // restart coinciding with the final sample edge
        drive_start(c);
        drive_bits(8'hF0, FL - 1);
        drive_start(c2);
        drive_bits(8'h5A, W);
`ifdef SIPO_PARITY_EN
        tick();
        start = 1'b0;
        ser   = 1'b0;
`endif
        push_exp(c2 + LAT, 8'h5A, 1'b0);
        idle(3);

        // back-to-back frames
        send(8'h01, 1'b1, c);
        send(8'h80, 1'b1, c2);
        idle(4);

`ifdef SIPO_PARITY_EN
        send_p(8'h07, 1'b1, 1'b1, c);
        idle(3);
        send_p(8'h07, 1'b0, 1'b1, c);
        idle(3);
`endif

        idle(3);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
